// File: rtl/bus_pkg.sv
// bus_pkg: shared widths, bus typedefs and arbiter state encoding.
package bus_pkg;
   localparam int ADDR_W_DEF = 14;
   localparam int MEM_W_DEF  = 16;
   typedef logic [ADDR_W_DEF-1:0] addr_t;
   typedef logic [MEM_W_DEF-1:0]  mem_t;
   typedef enum logic [1:0] {IDLE, OWN, RECOVER} arb_state_t;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: per-master request buses plus the shared slave-side bus.
interface bus_arbiter_if import bus_pkg::*; #(
   parameter int ADDR_WIDTH = ADDR_W_DEF,
   parameter int MEM_WIDTH  = MEM_W_DEF,
   parameter int NMASTERS   = 2
) ();
   logic [NMASTERS-1:0]            m_cyc;
   logic [NMASTERS-1:0]            m_write;
   logic [NMASTERS*ADDR_WIDTH-1:0] m_addr;
   logic [NMASTERS*MEM_WIDTH-1:0]  m_wrdata;
   logic [MEM_WIDTH-1:0]           m_rddata;
   logic [NMASTERS-1:0]            m_ack;
   logic [NMASTERS-1:0]            m_err;
   logic [ADDR_WIDTH-1:0]          s_addr;
   logic [MEM_WIDTH-1:0]           s_wrdata;
   logic                           s_cyc;
   logic                           s_write;
   logic [MEM_WIDTH-1:0]           s_rddata;
   logic                           s_ack;
   logic [NMASTERS-1:0]            grant;
   modport slave (
      input  m_cyc, m_write, m_addr, m_wrdata, s_rddata, s_ack,
      output m_rddata, m_ack, m_err, s_addr, s_wrdata, s_cyc, s_write, grant
   );
   modport master (
      output m_cyc, m_write, m_addr, m_wrdata, s_rddata, s_ack,
      input  m_rddata, m_ack, m_err, s_addr, s_wrdata, s_cyc, s_write, grant
   );
endinterface

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational round-robin selector, search starts after last_i.
module arb_rr_pick #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  win_o,
   output logic          valid_o
);
   always_comb begin
      logic [IW-1:0] idx;
      win_o   = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(last_i) + k) % N);
         if (!valid_o && req_i[idx]) begin
            win_o[idx] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: non-preemptive round-robin bus arbiter with slave timeout recovery.
module bus_arbiter import bus_pkg::*; #(
   parameter int ADDR_WIDTH = ADDR_W_DEF,
   parameter int MEM_WIDTH  = MEM_W_DEF,
   parameter int NMASTERS   = 2,
   parameter int TIMEOUT    = 15
) (
   input logic         clk,
   input logic         rst,
   bus_arbiter_if.slave bus
);
   localparam int IW = $clog2(NMASTERS);
   arb_state_t            state_q, state_d;
   logic [NMASTERS-1:0]   grant_q, grant_d, win;
   logic [IW-1:0]         last_q, last_d, own_idx;
   logic [7:0]            cnt_q, cnt_d;
   logic                  valid, own, cyc, write, tmo;
   logic [ADDR_WIDTH-1:0] addr;
   logic [MEM_WIDTH-1:0]  wrdata;

   arb_rr_pick #(.N(NMASTERS)) u_pick (
      .req_i  (bus.m_cyc),
      .last_i (last_q),
      .win_o  (win),
      .valid_o(valid)
   );

   always_comb begin
      cyc     = 1'b0;
      write   = 1'b0;
      addr    = '0;
      wrdata  = '0;
      own_idx = '0;
      for (int i = 0; i < NMASTERS; i++) begin
         if (grant_q[i]) begin
            cyc     = bus.m_cyc[i];
            write   = bus.m_write[i];
            addr    = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wrdata  = bus.m_wrdata[i*MEM_WIDTH +: MEM_WIDTH];
            own_idx = IW'(i);
         end
      end
   end

   assign own          = state_q == OWN;
   assign bus.s_cyc    = own & cyc;
   assign bus.s_write  = own & write;
   assign bus.s_addr   = own ? addr : '0;
   assign bus.s_wrdata = own ? wrdata : '0;
   assign bus.m_rddata = bus.s_rddata;
   assign bus.m_ack    = {NMASTERS{own & bus.s_ack}} & grant_q;
   // an ack on the would-be timeout cycle wins, so tmo requires s_ack low
   assign tmo          = bus.s_cyc & ~bus.s_ack & (cnt_q == 8'(TIMEOUT - 1));
   assign bus.m_err    = {NMASTERS{tmo}} & grant_q;
   assign bus.grant    = grant_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            state_d = valid ? OWN : IDLE;
            grant_d = valid ? win : '0;
         end
         OWN: begin
            cnt_d = (bus.s_ack || !cyc) ? '0 : cnt_q + 8'd1;
            if (!cyc) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = own_idx;
            end else if (tmo) begin
               state_d = RECOVER;
            end
         end
         RECOVER: begin
            if (!cyc) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = own_idx;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IW'(NMASTERS - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, bus address width.
REQ-002 Parameter MEM_WIDTH, default 16, bus data width.
REQ-003 Parameter NMASTERS, default 2, number of requesters; legal range 2..4.
REQ-004 Parameter TIMEOUT, default 15, maximum cycles s_cyc may be high without s_ack; legal range 1..255.
REQ-005 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  clock; all state SHALL change on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 m_cyc  input  NMASTERS  per-master bus request, held high for the whole transfer.
REQ-009 m_write  input  NMASTERS  per-master write strobe.
REQ-010 m_addr  input  NMASTERS*ADDR_WIDTH  per-master address, packed with master 0 in the LSBs.
REQ-011 m_wrdata  input  NMASTERS*MEM_WIDTH  per-master write data, packed with master 0 in the LSBs.
REQ-012 m_rddata  output  MEM_WIDTH  read data, broadcast to all masters.
REQ-013 m_ack  output  NMASTERS  per-master acknowledge.
REQ-014 m_err  output  NMASTERS  per-master timeout error pulse.
REQ-015 s_addr, s_wrdata, s_cyc, s_write  output  ADDR_WIDTH / MEM_WIDTH / 1 / 1  slave-side bus.
REQ-016 s_rddata, s_ack  input  MEM_WIDTH / 1  slave-side response.
REQ-017 grant  output  NMASTERS  one-hot current owner, all zero when no master owns the bus.

Function
REQ-018 The FSM SHALL have three states: IDLE, OWN and RECOVER.
REQ-019 IDLE with any m_cyc high: at the next edge the arbiter SHALL register the round-robin winner into grant and enter OWN (request-to-s_cyc latency is 1 cycle).
REQ-020 Round-robin: the search SHALL start at index last_owner+1 modulo NMASTERS, and last_owner SHALL reset to NMASTERS-1, so master 0 wins first.
REQ-021 In OWN, the s_* outputs SHALL be combinationally muxed from the owner's m_* inputs, with s_cyc = m_cyc[owner].
REQ-022 m_ack[i] SHALL be s_ack AND (state==OWN) AND grant[i]; m_rddata SHALL equal s_rddata at all times.
REQ-023 Outside OWN, s_cyc and s_write SHALL be 0, and s_addr and s_wrdata SHALL be 0.
REQ-024 OWN with m_cyc[owner] low: at the next edge the arbiter SHALL go to IDLE, clear grant and update last_owner; at least one IDLE cycle SHALL separate successive owners.
REQ-025 A master's new requests SHALL NOT preempt an existing owner; grant SHALL be stable throughout OWN.
REQ-026 The 8-bit timeout counter SHALL clear on entry to OWN and on each s_ack, and SHALL increment on each OWN cycle with s_cyc high and s_ack low.
REQ-027 When the counter reaches TIMEOUT, the arbiter SHALL pulse m_err[owner] for 1 cycle and enter RECOVER.
REQ-028 In RECOVER, m_ack SHALL be 0 and s_cyc SHALL be 0; the arbiter SHALL go to IDLE once m_cyc[owner] is low.
REQ-029 s_ack arriving in the same cycle the timeout count is reached SHALL take precedence: the arbiter SHALL ack, SHALL NOT raise an error, and the counter SHALL clear.
REQ-030 s_ack outside OWN SHALL be ignored.

Reset
REQ-031 While rst is high: state=IDLE, grant=0, m_ack=0, m_err=0, s_cyc=0, s_write=0, counter=0, last_owner=NMASTERS-1.
REQ-032 Reset asserted mid-transfer SHALL drop s_cyc immediately (asynchronously); no ack or err SHALL be issued for that transfer.

Structure
REQ-033 Package bus_pkg SHALL hold the ADDR and MEM typedefs, the arb_state_t enum {IDLE, OWN, RECOVER} and the default width constants.
REQ-034 Sub-module arb_rr_pick SHALL be the combinational round-robin selector: inputs req and last_owner, outputs a one-hot winner and a valid flag.

Verification
REQ-035 Single requester: m_cyc=01 at cycle 0 -> grant=01 and s_cyc=1 at cycle 1; s_ack at cycle 3 -> m_ack[0]=1 at cycle 3.
REQ-036 Contention after reset: m_cyc=11 -> master 0 owns first; after it drops cyc, one IDLE cycle, then grant=10.
REQ-037 Fairness: both masters requesting continuously for 8 transfers -> grants alternate 01,10,01,... with no master served twice in a row.
REQ-038 Timeout: TIMEOUT=4, slave never acks -> m_err[owner] pulses at the 4th stalled cycle, s_cyc=0 next cycle, IDLE after m_cyc drops.
REQ-039 Ack/timeout collision: s_ack arrives on the cycle the count reaches TIMEOUT -> m_ack=1, m_err stays 0.
REQ-040 Reset mid-write: rst asserted while OWN with s_write=1 -> s_cyc, s_write and grant go to 0 in the same cycle; normal arbitration resumes after release.
